sha256_msg_sequencer: RTL

//  Front-end controller for the SHA-256 round core. Accepts a message as a stream of
//  32-bit big-endian words, assembles 512-bit blocks, performs FIPS 180-4 padding
//  (0x80, zeros, 64-bit bit-length), issues blocks to the core with the next/core_ready

---
 rtl/sha256_msg_sequencer_if.sv | 40 ++++
 rtl/sha256_msg_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sequencer_if.sv
// Bus bundle for sha256_msg_sequencer.
//   s_*          : 32-bit big-endian message word stream in (valid/ready, last, byte count)
//   core_*       : 512-bit block out to the SHA-256 round core (next/init pulse, ready),
//                  256-bit chaining value back from the core (digest_we strobe)
//   digest*      : final 256-bit digest out (valid/ready)
// Modport slave is the sequencer; modport master is the message source / core / sink side.
interface sha256_msg_sequencer_if;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic [2:0]   s_bytes;
  logic         s_ready;
  logic [511:0] core_block;
  logic         core_init;
  logic         core_next;
  logic         core_ready;
  logic         core_digest_we;
  logic [255:0] core_digest;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  modport slave (
    input  s_data, s_valid, s_last, s_bytes,
    output s_ready,
    output core_block, core_init, core_next,
    input  core_ready, core_digest_we, core_digest,
    output digest, digest_valid,
    input  digest_ready
  );

  modport master (
    output s_data, s_valid, s_last, s_bytes,
    input  s_ready,
    input  core_block, core_init, core_next,
    output core_ready, core_digest_we, core_digest,
    input  digest, digest_valid,
    output digest_ready
  );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// SHA-256 front-end: packs a 32-bit word stream into 512-bit blocks, applies message padding
// (0x80, zeros, 64-bit bit length), feeds blocks to the round core and returns the digest.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sha256_msg_sequencer_if.slave (word stream in, core handshake, digest out)
module sha256_msg_sequencer #(
  parameter int unsigned LEN_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  sha256_msg_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StFill, StPad, StIssue, StWait, StOut} state_e;

  state_e             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               first_q, first_d;
  logic               need_extra_q, need_extra_d;
  logic               pad80_q, pad80_d;
  logic               ended_q, ended_d;
  logic [3:0]         last_w_q, last_w_d;
  logic [2:0]         last_k_q, last_k_d;
  logic [255:0]       digest_q, digest_d;

  logic [2:0]         k_in;
  logic [6:0]         pad_pos;
  logic [63:0]        bit_len;

  // Out-of-range byte counts are treated as a full word so the pad position stays in range.
  assign k_in    = (bus.s_bytes > 3'd4) ? 3'd4 : bus.s_bytes;
  assign pad_pos = {1'b0, last_w_q, 2'b00} + {4'b0000, last_k_q};
  assign bit_len = 64'({byte_cnt_q, 3'b000});

  assign bus.core_block   = blk_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = (state_q == StOut) && !rst;

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    wcnt_d       = wcnt_q;
    byte_cnt_d   = byte_cnt_q;
    first_d      = first_q;
    need_extra_d = need_extra_q;
    pad80_d      = pad80_q;
    ended_d      = ended_q;
    last_w_d     = last_w_q;
    last_k_d     = last_k_q;
    digest_d     = digest_q;
    bus.s_ready   = 1'b0;
    bus.core_next = 1'b0;
    bus.core_init = 1'b0;

    unique case (state_q)
      StFill: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          // Word w occupies bits [511-32w -: 32]; {~w, 5'h1f} is that top bit index.
          blk_d[{~wcnt_q, 5'h1f} -: 32] = bus.s_data;
          byte_cnt_d = byte_cnt_q + LEN_W'(bus.s_last ? k_in : 3'd4);
          wcnt_d     = wcnt_q + 4'd1;
          if (bus.s_last) begin
            last_w_d = wcnt_q;
            last_k_d = k_in;
            ended_d  = 1'b1;
            state_d  = StPad;
          end else if (wcnt_q == 4'd15) begin
            state_d = StIssue;
          end
        end
      end
      StPad: begin
        // Byte pad_pos gets the 0x80 marker, everything after it is cleared (this also
        // scrubs unused bytes of the last word).
        for (int i = 0; i < 64; i++) begin
          if (i == int'(pad_pos)) begin
            blk_d[511-8*i -: 8] = 8'h80;
          end else if (i > int'(pad_pos)) begin
            blk_d[511-8*i -: 8] = 8'h00;
          end
        end
        if (pad_pos <= 7'd55) begin
          blk_d[63:0]  = bit_len;
          need_extra_d = 1'b0;
          pad80_d      = 1'b0;
        end else begin
          // No room for the length; a full last block also has no room for the marker.
          need_extra_d = 1'b1;
          pad80_d      = (pad_pos == 7'd64);
        end
        state_d = StIssue;
      end
      StIssue: begin
        if (bus.core_ready) begin
          bus.core_next = 1'b1;
          bus.core_init = first_q;
          first_d       = 1'b0;
          state_d       = StWait;
        end
      end
      StWait: begin
        if (bus.core_digest_we) begin
          if (!ended_q) begin
            blk_d   = '0;
            wcnt_d  = '0;
            state_d = StFill;
          end else if (need_extra_q) begin
            blk_d          = '0;
            blk_d[511:504] = pad80_q ? 8'h80 : 8'h00;
            blk_d[63:0]    = bit_len;
            need_extra_d   = 1'b0;
            pad80_d        = 1'b0;
            state_d        = StIssue;
          end else begin
            digest_d = bus.core_digest;
            state_d  = StOut;
          end
        end
      end
      StOut: begin
        if (bus.digest_ready) begin
          blk_d      = '0;
          wcnt_d     = '0;
          byte_cnt_d = '0;
          first_d    = 1'b1;
          ended_d    = 1'b0;
          state_d    = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    if (rst) begin
      bus.s_ready   = 1'b0;
      bus.core_next = 1'b0;
      bus.core_init = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      blk_q        <= '0;
      wcnt_q       <= '0;
      byte_cnt_q   <= '0;
      first_q      <= 1'b1;
      need_extra_q <= 1'b0;
      pad80_q      <= 1'b0;
      ended_q      <= 1'b0;
      last_w_q     <= '0;
      last_k_q     <= '0;
      digest_q     <= '0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      wcnt_q       <= wcnt_d;
      byte_cnt_q   <= byte_cnt_d;
      first_q      <= first_d;
      need_extra_q <= need_extra_d;
      pad80_q      <= pad80_d;
      ended_q      <= ended_d;
      last_w_q     <= last_w_d;
      last_k_q     <= last_k_d;
      digest_q     <= digest_d;
    end
  end

endmodule
